// File: rtl/board_line_clear_if.sv
// -----------------------------------------------------------------------------
// board_line_clear_if
//   Groups the request/status handshake and the board BRAM port of the
//   line-clear engine.
//
//   Signals
//     i_Start          request pulse from the game FSM
//     o_Busy           engine is working on the board
//     o_Done           one-cycle completion pulse
//     o_Lines_Cleared  rows removed by the last operation
//     o_Rd_Addr        BRAM read address
//     i_Rd_Data        BRAM read data, one cycle after o_Rd_Addr
//     o_Wr_Addr        BRAM write address
//     o_Wr_Data        BRAM write data
//     o_Wr_En          BRAM write strobe
//
//   Modports
//     master : game FSM plus BRAM side (drives start and read data)
//     slave  : the line-clear engine
// -----------------------------------------------------------------------------
interface board_line_clear_if #(
   parameter int ADDR_W = 11
);
   logic              i_Start;
   logic              o_Busy;
   logic              o_Done;
   logic [4:0]        o_Lines_Cleared;
   logic [ADDR_W-1:0] o_Rd_Addr;
   logic [15:0]       i_Rd_Data;
   logic [ADDR_W-1:0] o_Wr_Addr;
   logic [15:0]       o_Wr_Data;
   logic              o_Wr_En;

   modport master (
      output i_Start, i_Rd_Data,
      input  o_Busy, o_Done, o_Lines_Cleared, o_Rd_Addr, o_Wr_Addr, o_Wr_Data, o_Wr_En
   );

   modport slave (
      input  i_Start, i_Rd_Data,
      output o_Busy, o_Done, o_Lines_Cleared, o_Rd_Addr, o_Wr_Addr, o_Wr_Data, o_Wr_En
   );
endinterface

// File: rtl/board_line_clear.sv
// -----------------------------------------------------------------------------
// board_line_clear
//   Post-lock line-clear engine for the playfield tile map in the board BRAM.
//   On a start request it scans rows bottom to top, drops every full row,
//   compacts the surviving rows downward, fills the vacated top rows with
//   EMPTY_TILE and reports how many rows were removed.
//
//   Ports
//     i_Clk    system clock
//     i_Rst_L  asynchronous active-low reset (aborts any operation; the board
//              is then left partially updated)
//     bus      board_line_clear_if.slave: start/busy/done/line count and the
//              BRAM read and write ports
// -----------------------------------------------------------------------------
module board_line_clear #(
   parameter int         ROWS       = 15,
   parameter int         COLS       = 12,
   parameter int         ROW_STRIDE = 16,
   parameter int         BASE_ADDR  = 0,
   parameter logic [3:0] EMPTY_TILE = 4'hF,
   parameter int         ADDR_W     = 11
) (
   input logic               i_Clk,
   input logic               i_Rst_L,
   board_line_clear_if.slave bus
);

   localparam int WPR    = COLS / 4;             // 16-bit words per row
   localparam int ROW_W  = $clog2(ROWS + 1) + 1;  // signed: rows may step to -1
   localparam int WCNT_W = $clog2(WPR + 1);       // counts 0..WPR

   typedef enum logic [2:0] {S_IDLE, S_RD, S_EVAL, S_WR, S_FILL, S_DONE} state_t;

   state_t                    state_reg;
   logic signed [ROW_W-1:0]   src_reg;
   logic signed [ROW_W-1:0]   dst_reg;
   logic        [WCNT_W-1:0]  word_reg;
   logic        [15:0]        row_buf [WPR];
   logic        [4:0]         lines_reg;
   logic                      busy_reg;
   logic                      done_reg;
   logic                      wr_en_reg;
   logic        [ADDR_W-1:0]  rd_addr_reg;
   logic        [ADDR_W-1:0]  wr_addr_reg;
   logic        [15:0]        wr_data_reg;

   // Full-row detection: every nibble of the buffered row must be occupied.
   logic [WPR*4-1:0] nib_ok;
   logic             row_full;

   genvar gi;
   generate
      for (gi = 0; gi < WPR * 4; gi++) begin : g_nib
         assign nib_ok[gi] = (row_buf[gi / 4][(gi % 4) * 4 +: 4] != EMPTY_TILE);
      end
   endgenerate

   assign row_full = &nib_ok;

   // Row pointers after finishing the current row. A full row only moves the
   // source; a surviving row (kept in place or copied) moves both.
   logic signed [ROW_W-1:0] adv_src;
   logic signed [ROW_W-1:0] adv_dst;
   logic                    do_advance;

   always_comb begin
      adv_src    = src_reg - ROW_W'(1);
      adv_dst    = (state_reg == S_EVAL && row_full) ? dst_reg : dst_reg - ROW_W'(1);
      do_advance = 1'b0;
      if (state_reg == S_EVAL)
         do_advance = row_full || (dst_reg == src_reg);
      else if (state_reg == S_WR)
         do_advance = (word_reg == WCNT_W'(WPR - 1));
   end

   function automatic logic [ADDR_W-1:0] row_addr(input logic signed [ROW_W-1:0] row,
                                                  input logic [WCNT_W-1:0] word);
      return ADDR_W'(BASE_ADDR + int'(row) * ROW_STRIDE + int'(word));
   endfunction

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_reg   <= S_IDLE;
         src_reg     <= '0;
         dst_reg     <= '0;
         word_reg    <= '0;
         lines_reg   <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         wr_en_reg   <= 1'b0;
         rd_addr_reg <= '0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         for (int i = 0; i < WPR; i++) row_buf[i] <= '0;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               if (bus.i_Start) begin
                  lines_reg   <= '0;
                  src_reg     <= ROW_W'(ROWS - 1);
                  dst_reg     <= ROW_W'(ROWS - 1);
                  word_reg    <= '0;
                  busy_reg    <= 1'b1;
                  rd_addr_reg <= row_addr(ROW_W'(ROWS - 1), '0);
                  state_reg   <= S_RD;
               end
            end

            // word_reg = cycle index within the read burst. Address k is on
            // the bus in cycle k; its data is captured at the end of cycle k+1.
            S_RD: begin
               if (word_reg != '0)
                  row_buf[word_reg - WCNT_W'(1)] <= bus.i_Rd_Data;
               if (word_reg < WCNT_W'(WPR - 1))
                  rd_addr_reg <= row_addr(src_reg, word_reg + WCNT_W'(1));
               if (word_reg == WCNT_W'(WPR))
                  state_reg <= S_EVAL;
               else
                  word_reg <= word_reg + WCNT_W'(1);
            end

            S_EVAL: begin
               if (row_full) begin
                  if (lines_reg != 5'(ROWS))
                     lines_reg <= lines_reg + 5'd1;
               end else if (dst_reg != src_reg) begin
                  word_reg    <= '0;
                  wr_en_reg   <= 1'b1;
                  wr_addr_reg <= row_addr(dst_reg, '0);
                  wr_data_reg <= row_buf[0];
                  state_reg   <= S_WR;
               end
            end

            S_WR: begin
               if (word_reg != WCNT_W'(WPR - 1)) begin
                  word_reg    <= word_reg + WCNT_W'(1);
                  wr_addr_reg <= row_addr(dst_reg, word_reg + WCNT_W'(1));
                  wr_data_reg <= row_buf[word_reg + WCNT_W'(1)];
               end else begin
                  wr_en_reg <= 1'b0;
               end
            end

            // dst_reg walks up from the lowest vacated row to row 0.
            S_FILL: begin
               if (word_reg != WCNT_W'(WPR - 1)) begin
                  word_reg    <= word_reg + WCNT_W'(1);
                  wr_addr_reg <= row_addr(dst_reg, word_reg + WCNT_W'(1));
               end else if (dst_reg == '0) begin
                  wr_en_reg <= 1'b0;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= S_DONE;
               end else begin
                  dst_reg     <= dst_reg - ROW_W'(1);
                  word_reg    <= '0;
                  wr_addr_reg <= row_addr(dst_reg - ROW_W'(1), '0);
               end
            end

            S_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end

            default: state_reg <= S_IDLE;
         endcase

         // Shared exit from EVAL and the last WR word: step the pointers and
         // pick the next phase. Overrides the assignments made above.
         if (do_advance) begin
            src_reg  <= adv_src;
            dst_reg  <= adv_dst;
            word_reg <= '0;
            if (adv_src[ROW_W-1]) begin
               if (!adv_dst[ROW_W-1]) begin
                  wr_en_reg   <= 1'b1;
                  wr_addr_reg <= row_addr(adv_dst, '0);
                  wr_data_reg <= {4{EMPTY_TILE}};
                  state_reg   <= S_FILL;
               end else begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= S_DONE;
               end
            end else begin
               rd_addr_reg <= row_addr(adv_src, '0);
               state_reg   <= S_RD;
            end
         end
      end
   end

   assign bus.o_Busy          = busy_reg;
   assign bus.o_Done          = done_reg;
   assign bus.o_Lines_Cleared = lines_reg;
   assign bus.o_Rd_Addr       = rd_addr_reg;
   assign bus.o_Wr_Addr       = wr_addr_reg;
   assign bus.o_Wr_Data       = wr_data_reg;
   assign bus.o_Wr_En         = wr_en_reg;

endmodule

// File: tb/tb_board_line_clear.sv
// -----------------------------------------------------------------------------
// tb_board_line_clear
//   Self-checking bench for board_line_clear with a behavioural board BRAM.
//   Expected line count, latency, write count and final board are pushed to
//   scoreboard queues when an operation is started and popped on o_Done.
// -----------------------------------------------------------------------------
module tb_board_line_clear;
   localparam int ROWS   = 15;
   localparam int WPR    = 3;
   localparam int STRIDE = 16;
   localparam int ADDR_W = 11;

   logic i_Clk   = 1'b0;
   logic i_Rst_L = 1'b0;

   always #20 i_Clk = ~i_Clk;

   board_line_clear_if #(.ADDR_W(ADDR_W)) bus ();

   board_line_clear #(
      .ROWS(ROWS), .COLS(12), .ROW_STRIDE(STRIDE), .BASE_ADDR(0),
      .EMPTY_TILE(4'hF), .ADDR_W(ADDR_W)
   ) dut (
      .i_Clk  (i_Clk),
      .i_Rst_L(i_Rst_L),
      .bus    (bus)
   );

   logic [15:0] mem [0:2047];

   always @(posedge i_Clk) begin
      bus.i_Rd_Data <= mem[bus.o_Rd_Addr];
      if (bus.o_Wr_En === 1'b1) mem[bus.o_Wr_Addr] <= bus.o_Wr_Data;
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_lines_q[$];
   int          exp_lat_q[$];
   int          exp_wr_q[$];
   logic [15:0] exp_board_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pat(input int r, input int w);
      return {4'hF, 4'(r), 4'(w), 4'hA};
   endfunction

   task automatic load_board(input int kind);
      for (int r = 0; r < ROWS; r++) begin
         for (int w = 0; w < WPR; w++) begin
            logic [15:0] v;
            v = pat(r, w);
            case (kind)
               3: if (r == 14) v = 16'h2222;
               4: begin
                  if (r == 14) v = 16'h2222;
                  if (r == 12) v = 16'h3333;
               end
               5: v = {4'(r), 4'(w), 4'h1, 4'h2};
               6: begin
                  if (r == 14) v = (w == 2) ? 16'h22F2 : 16'h2222;
                  if (r == 5)  v = 16'h5555;
               end
               default: ;
            endcase
            mem[r * STRIDE + w] <= v;
         end
      end
      @(negedge i_Clk);
   endtask

   // Reference: keep non-full rows in order at the bottom, empties on top.
   task automatic model_push();
      logic [15:0] res [ROWS][WPR];
      int k, copies, d;
      k = 0; copies = 0; d = ROWS - 1;
      for (int r = 0; r < ROWS; r++)
         for (int w = 0; w < WPR; w++) res[r][w] = 16'hFFFF;
      for (int r = ROWS - 1; r >= 0; r--) begin
         bit full;
         full = 1'b1;
         for (int w = 0; w < WPR; w++)
            for (int n = 0; n < 4; n++)
               if (mem[r * STRIDE + w][n * 4 +: 4] == 4'hF) full = 1'b0;
         if (full) k++;
         else begin
            if (d != r) copies++;
            for (int w = 0; w < WPR; w++) res[d][w] = mem[r * STRIDE + w];
            d--;
         end
      end
      exp_lines_q.push_back(k);
      exp_wr_q.push_back(WPR * (copies + k));
      exp_lat_q.push_back(ROWS * (WPR + 2) + WPR * (copies + k));
      for (int r = 0; r < ROWS; r++)
         for (int w = 0; w < WPR; w++) exp_board_q.push_back(res[r][w]);
   endtask

   task automatic run_op(input string name, input bit extra_start);
      int cyc, wr, late_done, late_busy;
      model_push();
      @(negedge i_Clk) bus.i_Start = 1'b1;
      @(negedge i_Clk) bus.i_Start = 1'b0;
      check_eq({name, ".busy_after_start"}, 32'(bus.o_Busy), 1);
      cyc = 0; wr = 0;
      while (bus.o_Done !== 1'b1 && cyc < 2000) begin
         if (bus.o_Wr_En === 1'b1) wr++;
         bus.i_Start = (extra_start && cyc == 10);
         @(negedge i_Clk);
         cyc++;
      end
      bus.i_Start = 1'b0;
      check_eq({name, ".done_seen"}, 32'(bus.o_Done), 1);
      check_eq({name, ".busy_at_done"}, 32'(bus.o_Busy), 0);
      check_eq({name, ".latency"}, cyc, exp_lat_q.pop_front());
      check_eq({name, ".writes"}, wr, exp_wr_q.pop_front());
      check_eq({name, ".lines"}, 32'(bus.o_Lines_Cleared), exp_lines_q.pop_front());
      @(negedge i_Clk);
      check_eq({name, ".done_pulse"}, 32'(bus.o_Done), 0);
      if (extra_start) begin
         late_done = 0; late_busy = 0;
         for (int i = 0; i < 100; i++) begin
            if (bus.o_Done === 1'b1) late_done++;
            if (bus.o_Busy === 1'b1) late_busy++;
            @(negedge i_Clk);
         end
         check_eq({name, ".extra_done"}, late_done, 0);
         check_eq({name, ".extra_busy"}, late_busy, 0);
      end
      for (int r = 0; r < ROWS; r++)
         for (int w = 0; w < WPR; w++)
            check_eq($sformatf("%s.r%0dw%0d", name, r, w), 32'(mem[r * STRIDE + w]),
                     32'(exp_board_q.pop_front()));
      $display("op %s: lines=%0d latency=%0d writes=%0d", name, bus.o_Lines_Cleared, cyc, wr);
   endtask

   initial begin
      int wait_cyc;
      bus.i_Start = 1'b0;
      for (int a = 0; a < 2048; a++) mem[a] <= 16'h0000;
      repeat (3) @(negedge i_Clk);

      check_eq("rst.busy",    32'(bus.o_Busy), 0);
      check_eq("rst.done",    32'(bus.o_Done), 0);
      check_eq("rst.wr_en",   32'(bus.o_Wr_En), 0);
      check_eq("rst.lines",   32'(bus.o_Lines_Cleared), 0);
      check_eq("rst.rd_addr", 32'(bus.o_Rd_Addr), 0);
      check_eq("rst.wr_addr", 32'(bus.o_Wr_Addr), 0);
      check_eq("rst.wr_data", 32'(bus.o_Wr_Data), 0);
      $display("op reset: outputs checked");
      i_Rst_L = 1'b1;
      @(negedge i_Clk);

      load_board(2);
      run_op("no_full", 1'b0);

      load_board(3);
      run_op("one_line", 1'b0);

      // Abort with reset while a copy write is in progress.
      load_board(3);
      @(negedge i_Clk) bus.i_Start = 1'b1;
      @(negedge i_Clk) bus.i_Start = 1'b0;
      wait_cyc = 0;
      while (bus.o_Wr_En !== 1'b1 && wait_cyc < 200) begin
         @(negedge i_Clk);
         wait_cyc++;
      end
      check_eq("midwr.wr_seen", 32'(bus.o_Wr_En), 1);
      @(negedge i_Clk);
      i_Rst_L = 1'b0;
      #1;
      check_eq("midwr.wr_en", 32'(bus.o_Wr_En), 0);
      check_eq("midwr.busy",  32'(bus.o_Busy), 0);
      check_eq("midwr.lines", 32'(bus.o_Lines_Cleared), 0);
      $display("op midwr_reset: wr_en=%0d busy=%0d lines=%0d",
               bus.o_Wr_En, bus.o_Busy, bus.o_Lines_Cleared);
      @(negedge i_Clk) i_Rst_L = 1'b1;
      @(negedge i_Clk);

      load_board(4);
      run_op("two_lines", 1'b0);

      load_board(5);
      run_op("all_full", 1'b0);

      load_board(6);
      run_op("start_busy", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
